// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: column scanner, row synchroniser and whole-scan debouncer for a 4x4
// keypad. Emits a one-hot key vector (bit 4*row+col), a strobe on each newly accepted key and a
// multi-key flag when the debounced state has more than one key down.
// Build option: define KEYPAD_LATCH_EN to hold the last valid key across releases and strobe on
// every accepted transition into a single-key state.
module keypad_scan_debounce #(
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned DEBOUNCE_SCANS = 40
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  row_n,
   output logic [3:0]  col_n,
   output logic [15:0] keyout,
   output logic        key_strobe,
   output logic        multi_key
);

   localparam int unsigned SW = $clog2(SETTLE_CYCLES);
   localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_MAX  = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] STABLE_PRE  = CW'(DEBOUNCE_SCANS - 1);
   localparam logic          SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

   // IDLE only exists for the one clock after reset so column 0 is driven on the first edge
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_EVAL  = 2'd2;

   logic [3:0]    row_meta_q, row_sync_q;
   logic [1:0]    state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [15:0]   snap_q, snap_d;
   logic [15:0]   prev_q, prev_d;
   logic [CW-1:0] stable_q, stable_d;
   logic          accept_q, accept_d;
   logic [15:0]   deb_q, deb_d;
   logic [3:0]    coln_q, coln_d;
   logic [15:0]   keyout_q, keyout_d;
   logic          strobe_q, strobe_d;
   logic          multi_q, multi_d;
   logic          single_q, single_d;
   logic [4:0]    pop;

   // Two-flop synchroniser on the asynchronous row returns; idles at "no row pulled low"
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row_meta_q <= 4'b1111;
         row_sync_q <= 4'b1111;
      end else begin
         row_meta_q <= row_n;
         row_sync_q <= row_meta_q;
      end
   end

   // Scan sequencing, per-column snapshot capture and whole-scan stability counting
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      settle_d = settle_q;
      snap_d   = snap_q;
      prev_d   = prev_q;
      stable_d = stable_q;
      deb_d    = deb_q;
      coln_d   = coln_q;
      accept_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d  = ST_DRIVE;
            col_d    = 2'd0;
            settle_d = '0;
            coln_d   = 4'b1110;
         end
         ST_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               for (int r = 0; r < 4; r++) begin
                  snap_d[4*r + int'(col_q)] = ~row_sync_q[r];
               end
               if (col_q == 2'd3) begin
                  state_d = ST_EVAL;
                  col_d   = 2'd0;
                  coln_d  = 4'b1111;
               end else begin
                  col_d  = col_q + 2'd1;
                  coln_d = ~(4'b0001 << col_d);
               end
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         ST_EVAL: begin
            state_d = ST_DRIVE;
            coln_d  = 4'b1110;
            if (snap_q == prev_q) begin
               if (stable_q != STABLE_MAX) begin
                  stable_d = stable_q + CW'(1);
               end
               // accept only on the step into DEBOUNCE_SCANS, never while saturated
               accept_d = (stable_q == STABLE_PRE);
            end else begin
               prev_d   = snap_q;
               stable_d = CW'(1);
               accept_d = SINGLE_SCAN;
            end
            if (accept_d) begin
               deb_d = snap_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            coln_d  = 4'b1111;
         end
      endcase
   end

   // Scanner state registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         col_q    <= 2'd0;
         settle_q <= '0;
         snap_q   <= 16'h0;
         prev_q   <= 16'h0;
         stable_q <= '0;
         accept_q <= 1'b0;
         deb_q    <= 16'h0;
         coln_q   <= 4'b1111;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         settle_q <= settle_d;
         snap_q   <= snap_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         accept_q <= accept_d;
         deb_q    <= deb_d;
         coln_q   <= coln_d;
      end
   end

   // Classify the accepted state by key count and derive the output update
   always_comb begin
      pop = 5'd0;
      for (int i = 0; i < 16; i++) begin
         pop = pop + 5'(deb_q[i]);
      end
      keyout_d = keyout_q;
      multi_d  = multi_q;
      single_d = single_q;
      strobe_d = 1'b0;
      if (accept_q) begin
         if (pop == 5'd1) begin
            keyout_d = deb_q;
            multi_d  = 1'b0;
            single_d = 1'b1;
`ifdef KEYPAD_LATCH_EN
            // a fresh entry into a single-key state strobes even if it matches the held key
            strobe_d = (deb_q != keyout_q) || !single_q;
`else
            strobe_d = (deb_q != keyout_q);
`endif
         end else if (pop == 5'd0) begin
`ifndef KEYPAD_LATCH_EN
            keyout_d = 16'h0;
`endif
            multi_d  = 1'b0;
            single_d = 1'b0;
         end else begin
            // rollover: keep the last key, flag the ambiguity
            multi_d  = 1'b1;
            single_d = 1'b0;
         end
      end
   end

   // Output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         keyout_q <= 16'h0;
         strobe_q <= 1'b0;
         multi_q  <= 1'b0;
         single_q <= 1'b0;
      end else begin
         keyout_q <= keyout_d;
         strobe_q <= strobe_d;
         multi_q  <= multi_d;
         single_q <= single_d;
      end
   end

   assign col_n      = coln_q;
   assign keyout     = keyout_q;
   assign key_strobe = strobe_q;
   assign multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: keypad matrix model around the scanner, a directed vector table,
// hand-written corner sequences and randomized key holds checked against a hold-level model.
module tb_keypad_scan_debounce;

`ifdef KEYPAD_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] keyout;
   logic        key_strobe;
   logic        multi_key;
   logic [15:0] pressed = 16'h0;

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_cnt = 0;

   typedef struct {
      logic [15:0] keys;
      logic [15:0] exp_key;
      logic        exp_multi;
      int          exp_strobes;
   } vec_t;

   vec_t tbl[8];

   keypad_scan_debounce #(
      .SETTLE_CYCLES (4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .row_n     (row_n),
      .col_n     (col_n),
      .keyout    (keyout),
      .key_strobe(key_strobe),
      .multi_key (multi_key)
   );

   always #5 CLK = ~CLK;

   // Passive matrix: a row reads low when a pressed key sits on a driven column
   always_comb begin
      row_n = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         if (!col_n[c]) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[4*r + c]) row_n[r] = 1'b0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Hold-level reference: state after a held pattern has been accepted
   logic [15:0] m_key    = 16'h0;
   logic        m_multi  = 1'b0;
   logic        m_single = 1'b0;

   task automatic model_accept(input logic [15:0] p, output int strb);
      int n;
      n = $countones(p);
      strb = 0;
      if (n == 1) begin
         strb = ((p != m_key) || (LATCH && !m_single)) ? 1 : 0;
         m_key    = p;
         m_multi  = 1'b0;
         m_single = 1'b1;
      end else if (n == 0) begin
         if (!LATCH) m_key = 16'h0;
         m_multi  = 1'b0;
         m_single = 1'b0;
      end else begin
         m_multi  = 1'b1;
         m_single = 1'b0;
      end
   endtask

   initial begin
      logic [3:0]  exp_col;
      logic [15:0] one;
      logic [15:0] p;
      logic [15:0] last_p;
      int base;
      int strb;
      int idx;
      int sel;
      int a;
      int b;
      bit found;

      one = 16'h0001;

      tbl[0] = '{16'h0020, 16'h0020, 1'b0, 1};
      tbl[1] = '{16'h0000, LATCH ? 16'h0020 : 16'h0000, 1'b0, 0};
      tbl[2] = '{16'h8001, LATCH ? 16'h0020 : 16'h0000, 1'b1, 0};
      tbl[3] = '{16'h0001, 16'h0001, 1'b0, 1};
      tbl[4] = '{16'h2000, 16'h2000, 1'b0, 1};
      tbl[5] = '{16'h0000, LATCH ? 16'h2000 : 16'h0000, 1'b0, 0};
      tbl[6] = '{16'h2000, 16'h2000, 1'b0, 1};
      tbl[7] = '{16'h0400, 16'h0400, 1'b0, 1};

      // Reset values, then the column drive sequence from release
      tick(3);
      check("rst_col_n", 32'(col_n), 32'h0000000f);
      check("rst_keyout", 32'(keyout), 32'h0);
      check("rst_strobe", 32'(key_strobe), 32'h0);
      check("rst_multi", 32'(multi_key), 32'h0);
      RST = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         @(posedge CLK);
         #1;
         idx = (k - 1) % 17;
         exp_col = (idx < 16) ? ~(4'b0001 << (idx / 4)) : 4'b1111;
         check("col_seq", 32'(col_n), 32'(exp_col));
      end

      // '9' toggled once per scan period: no two consecutive scans agree, nothing accepted
      base = strobe_cnt;
      for (int i = 0; i < 12; i++) begin
         pressed = (i % 2 == 1) ? 16'h0400 : 16'h0000;
         tick(17);
         check("bounce_keyout", 32'(keyout), 32'h0);
      end
      check("bounce_strobes", 32'(strobe_cnt - base), 32'h0);
      base = strobe_cnt;
      pressed = 16'h0400;
      tick(120);
      check("bounce_settle_keyout", 32'(keyout), 32'h0400);
      check("bounce_settle_strobes", 32'(strobe_cnt - base), 32'h1);

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         base = strobe_cnt;
         pressed = tbl[i].keys;
         tick(120);
         check("tbl_keyout", 32'(keyout), 32'(tbl[i].exp_key));
         check("tbl_multi", 32'(multi_key), 32'(tbl[i].exp_multi));
         check("tbl_strobes", 32'(strobe_cnt - base), 32'(tbl[i].exp_strobes));
      end

      // Hold 'c' to acceptance, then reset in the middle of driving column 1
      pressed = 16'h0800;
      tick(120);
      check("midrst_pre_keyout", 32'(keyout), 32'h0800);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge CLK);
         if (col_n == 4'b1101) found = 1'b1;
      end
      check("midrst_found_col1", 32'(found), 32'h1);
      RST = 1'b1;
      #1;
      check("midrst_col_n", 32'(col_n), 32'h0000000f);
      check("midrst_keyout", 32'(keyout), 32'h0);
      check("midrst_strobe", 32'(key_strobe), 32'h0);
      check("midrst_multi", 32'(multi_key), 32'h0);
      tick(3);
      RST = 1'b0;
      base = strobe_cnt;
      // history was discarded: two fresh scans are needed before acceptance
      tick(30);
      check("midrst_early_keyout", 32'(keyout), 32'h0);
      tick(40);
      check("midrst_reaccept_keyout", 32'(keyout), 32'h0800);
      check("midrst_reaccept_strobes", 32'(strobe_cnt - base), 32'h1);

      // Randomized holds against the hold-level model
      m_key    = 16'h0800;
      m_multi  = 1'b0;
      m_single = 1'b1;
      last_p   = 16'h0800;
      for (int i = 0; i < 40; i++) begin
         do begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
               p = 16'h0;
            end else if (sel < 8) begin
               p = one << $urandom_range(0, 15);
            end else begin
               a = $urandom_range(0, 15);
               do b = $urandom_range(0, 15); while (b == a);
               p = (one << a) | (one << b);
            end
         end while (p == last_p);
         last_p = p;
         model_accept(p, strb);
         base = strobe_cnt;
         pressed = p;
         tick($urandom_range(90, 130));
         check("rand_keyout", 32'(keyout), 32'(m_key));
         check("rand_multi", 32'(multi_key), 32'(m_multi));
         check("rand_strobes", 32'(strobe_cnt - base), 32'(strb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
